dmem_banked: RTL and testbench
==============================

Name: dmem_banked

Overview:
- Parametrised, single-port, word-addressed synchronous data memory for the pipeline's MEM stage. It is the successor to the fixed 256x32 data memory.
- Replaces the tri-state data bus with separate write-data and read-data buses.
- Adds:
  - per-byte write enables;
  - a valid/ready request handshake;
  - a configurable read latency (pipelined output);
  - an optional hardware clear-on-reset sequencer.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 8: word-address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1: read latency in clock edges, legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = array contents untouched by reset.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  a request is presented this cycle.
- req_ready  output  1  the block accepts a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables; bit i gates bits [8i+7:8i].
- rsp_valid  output  1  rsp_rdata holds read data this cycle.
- rsp_rdata  output  DATA_W  read data.

Behaviour:
- Reset:
  - One clock (clk). Reset rst is asynchronous and active-high.
  - While rst is high: req_ready=0, rsp_valid=0, rsp_rdata=0, all read-pipeline valid bits = 0, clear counter = 0.
  - FSM goes to INIT if CLEAR_ON_RESET=1, else to RUN.
- FSM states:
  - INIT:
    - Each rising edge writes 0 to word clr_cnt, then increments clr_cnt.
    - When clr_cnt==DEPTH-1 is written, the FSM moves to RUN.
    - INIT lasts exactly DEPTH edges after rst deasserts; req_ready=0 throughout.
  - RUN:
    - req_ready=1 continuously; no backpressure.
    - No transition out of RUN except via rst.
- Accept:
  - A request is accepted on an edge where req_valid && req_ready.
  - When req_ready=0, requests are ignored entirely: no array change, no response.
- Write:
  - On acceptance, for each i with req_be[i]=1, byte i of DM[req_addr] takes req_wdata byte i. Bytes with req_be[i]=0 keep their value.
  - req_be=0 is accepted as a no-op.
  - Writes produce no response.
- Read latency:
  - A read accepted at edge k drives rsp_valid=1 with rsp_rdata=DM[req_addr] (array value before edge k) for exactly one cycle, from after edge k+RD_LAT-1 until edge k+RD_LAT.
  - RD_LAT=1 therefore means data is visible right after the accepting edge.
- Pipelining:
  - One request per cycle.
  - Back-to-back reads give back-to-back rsp_valid pulses in issue order.
  - There is no reordering and no dropping.
- Read-after-write:
  - A read accepted on the edge after a write to the same address returns the new data, with byte enables applied.
  - A read and a write never coincide (single port).
- rsp_rdata hold:
  - When rsp_valid=0, rsp_rdata holds its last value. It is 0 after reset.
- Address:
  - Full ADDR_W range is valid. There is no wrap or out-of-range case.
- Reset mid-operation:
  - Reads in flight are discarded; rsp_valid drops immediately and asynchronously.
  - An INIT in progress restarts from address 0.
  - Words already cleared or written remain as-is until re-cleared.
- CLEAR_ON_RESET=0:
  - Array contents are undefined until first written.
  - Reads of unwritten words may return X; the bench must not check them.

Test Plan:
- Init: DEPTH=256, CLEAR_ON_RESET=1; pulse rst, then hold req_valid=1 read addr 0x05 from release -> req_ready=0 for exactly 256 edges, then 1; first response is 0x00000000; no response appears during INIT.
- Byte-enable write/read (RD_LAT=1): write 0x11223344 be=4'hF to 0x10, then write 0xAABBCCDD be=4'b0101 to 0x10, then read 0x10 -> rsp_valid on the next cycle with rsp_rdata=0x11BB33DD.
- Latency/throughput (RD_LAT=3): preload 0x01..0x04 with 0xA1..0xA4; read 0x01..0x04 on consecutive edges k..k+3 -> rsp_valid high from edge k+2 through k+6 exclusive, with data 0xA1, 0xA2, 0xA3, 0xA4 in order.
- Read-after-write: write 0xDEADBEEF to 0xFF at edge k, read 0xFF at edge k+1 -> 0xDEADBEEF; read 0xFF with req_valid=0 -> no response; write with be=0 -> contents unchanged.
- Reset mid-flight (RD_LAT=2): issue a read of 0x20, then assert rst before the response edge -> rsp_valid never pulses, rsp_rdata=0; INIT restarts with req_ready=0 for 256 edges.
- CLEAR_ON_RESET=0: after rst release, req_ready=1 on the first cycle; write 0x5 to 0x00 and read it back -> 0x00000005.

Source files
------------

// File: rtl/dmem_banked.sv
// Single-port word-addressed data memory with byte enables, valid/ready request
// handshake, pipelined read data and an optional clear-after-reset sequencer.
module dmem_banked #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned RD_LAT         = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned NBYTES = DATA_W / 8;

   typedef enum logic {S_INIT, S_RUN} state_t;
   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [ADDR_W-1:0]   w_clr_cnt_nxt;
   logic                w_clr_en;
   logic                w_accept;
   logic                w_wr_en;
   logic                w_rd_en;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [RD_LAT-1:0]   r_pv;
   logic [DATA_W-1:0]   r_pd [RD_LAT];

   // State register and clear counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= RST_STATE;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   // Next state: INIT sweeps every word once, then RUN until the next reset
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      w_clr_en      = 1'b0;
      case (r_state)
         S_INIT: begin
            w_clr_en      = ~rst;
            w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
            if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = S_RUN;
         end
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = RST_STATE;
      endcase
   end

   assign req_ready = (r_state == S_RUN) && !rst;
   assign w_accept  = req_valid && req_ready;
   assign w_wr_en   = w_accept && req_write;
   assign w_rd_en   = w_accept && !req_write;

   // Storage array; not reset so contents survive a reset when clearing is off
   always_ff @(posedge clk) begin
      if (w_clr_en) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (req_be[b]) r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   // Read pipeline; data stages only advance behind a valid so the output holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pv <= '0;
         for (int i = 0; i < RD_LAT; i++) r_pd[i] <= '0;
      end else begin
         r_pv[0] <= w_rd_en;
         if (w_rd_en) r_pd[0] <= r_mem[req_addr];
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
         end
      end
   end

   assign rsp_valid = r_pv[RD_LAT-1];
   assign rsp_rdata = r_pd[RD_LAT-1];

endmodule

// File: tb/tb_dmem_banked.sv
// Bench for dmem_banked: four configurations (latency 1/3/2 with clearing, latency 1
// without), directed requests with a cycle-tagged scoreboard checked by a monitor.
module tb_dmem_banked;

   localparam int NI = 4;

   typedef struct {
      int          inst;
      logic [31:0] data;
      longint      due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_v [NI];
   logic        vld   [NI];
   logic        wr    [NI];
   logic [7:0]  adr   [NI];
   logic [31:0] wd    [NI];
   logic [3:0]  be    [NI];
   logic        rdy   [NI];
   logic        rv    [NI];
   logic [31:0] rd    [NI];

   longint cyc = 0;
   int     n_vec = 0;
   int     n_err = 0;
   exp_t   q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_banked #(
         .DATA_W         (32),
         .ADDR_W         (8),
         .RD_LAT         ((g == 1) ? 3 : (g == 2) ? 2 : 1),
         .CLEAR_ON_RESET ((g == 3) ? 0 : 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst_v[g]),
         .req_valid (vld[g]),
         .req_ready (rdy[g]),
         .req_write (wr[g]),
         .req_addr  (adr[g]),
         .req_wdata (wd[g]),
         .req_be    (be[g]),
         .rsp_valid (rv[g]),
         .rsp_rdata (rd[g])
      );
   end

   function automatic int lat(input int i);
      return (i == 1) ? 3 : (i == 2) ? 2 : 1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // One request presented for exactly one edge; reads enqueue their expected response
   task automatic issue(input int i, input bit w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_d);
      @(posedge clk);
      #1;
      vld[i] = 1'b1; wr[i] = w; adr[i] = a; wd[i] = d; be[i] = b;
      if (!w) q.push_back('{inst: i, data: exp_d, due: cyc + longint'(lat(i))});
   endtask

   task automatic idle(input int i);
      @(posedge clk);
      #1;
      vld[i] = 1'b0; wr[i] = 1'b0;
   endtask

   task automatic count_init(input int i, input string name, input bit push_rd);
      int  zeros;
      bit  done;
      zeros = 0;
      done  = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         if (rdy[i] === 1'b1) begin
            done = 1'b1;
            if (push_rd) q.push_back('{inst: i, data: 32'h0, due: cyc + longint'(lat(i))});
         end else begin
            zeros++;
         end
      end
      check(name, 64'(zeros), 64'd256);
   endtask

   // Monitor: every response must match the head of the scoreboard in instance, data and cycle
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NI; i++) begin
         if (rv[i] === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_rsp: inst %0d got data %h at cycle %0d, required no response",
                        i, rd[i], cyc);
            end else begin
               e = q.pop_front();
               if (e.inst != i || e.data !== rd[i] || e.due != cyc) begin
                  n_err++;
                  $display("FAIL rsp: got inst %0d data %h cycle %0d, required inst %0d data %h cycle %0d",
                           i, rd[i], cyc, e.inst, e.data, e.due);
               end
            end
         end
      end
      if (q.size() > 0 && q[0].due < cyc) begin
         n_vec++;
         n_err++;
         $display("FAIL missing_rsp: got nothing by cycle %0d, required inst %0d data %h at cycle %0d",
                  cyc, q[0].inst, q[0].data, q[0].due);
         void'(q.pop_front());
      end
   end

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst_v[i] = 1'b1; vld[i] = 1'b0; wr[i] = 1'b0;
         adr[i] = '0; wd[i] = '0; be[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_ready_%0d", i), 64'(rdy[i]), 64'd0);
         check($sformatf("rst_rsp_valid_%0d", i), 64'(rv[i]), 64'd0);
         check($sformatf("rst_rdata_%0d", i), 64'(rd[i]), 64'd0);
      end

      // Release all; inst 0 holds a read of 0x05 through INIT
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
      vld[0] = 1'b1; wr[0] = 1'b0; adr[0] = 8'h05;
      #1;
      check("noclear_ready_first_cycle", 64'(rdy[3]), 64'd1);
      count_init(0, "init_ready_low_edges", 1'b1);
      idle(0);
      repeat (3) @(posedge clk);

      // Byte enables and read-after-write, latency 1
      issue(0, 1'b1, 8'h10, 32'h11223344, 4'hF, '0);
      issue(0, 1'b1, 8'h10, 32'hAABBCCDD, 4'b0101, '0);
      issue(0, 1'b0, 8'h10, '0, '0, 32'h11BB33DD);
      issue(0, 1'b1, 8'hFF, 32'hDEADBEEF, 4'hF, '0);
      issue(0, 1'b0, 8'hFF, '0, '0, 32'hDEADBEEF);
      idle(0);
      adr[0] = 8'hFF;
      issue(0, 1'b1, 8'hFF, 32'h12345678, 4'h0, '0);
      issue(0, 1'b0, 8'hFF, '0, '0, 32'hDEADBEEF);
      issue(0, 1'b0, 8'h00, '0, '0, 32'h00000000);
      idle(0);
      repeat (3) @(posedge clk);

      // Latency 3, back-to-back reads
      issue(1, 1'b1, 8'h01, 32'hA1, 4'hF, '0);
      issue(1, 1'b1, 8'h02, 32'hA2, 4'hF, '0);
      issue(1, 1'b1, 8'h03, 32'hA3, 4'hF, '0);
      issue(1, 1'b1, 8'h04, 32'hA4, 4'hF, '0);
      issue(1, 1'b0, 8'h01, '0, '0, 32'hA1);
      issue(1, 1'b0, 8'h02, '0, '0, 32'hA2);
      issue(1, 1'b0, 8'h03, '0, '0, 32'hA3);
      issue(1, 1'b0, 8'h04, '0, '0, 32'hA4);
      idle(1);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("hold_valid_low", 64'(rv[1]), 64'd0);
      check("hold_rdata", 64'(rd[1]), 64'hA4);

      // Latency 2, reset while a read is in flight
      issue(2, 1'b1, 8'h20, 32'h77, 4'hF, '0);
      issue(2, 1'b0, 8'h20, '0, '0, 32'h77);
      idle(2);
      repeat (3) @(posedge clk);
      @(posedge clk);
      #1;
      vld[2] = 1'b1; wr[2] = 1'b0; adr[2] = 8'h20;
      @(posedge clk);
      #1;
      rst_v[2] = 1'b1;
      vld[2]   = 1'b0;
      #1;
      check("midrst_rsp_valid", 64'(rv[2]), 64'd0);
      check("midrst_rdata", 64'(rd[2]), 64'd0);
      check("midrst_ready", 64'(rdy[2]), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_rsp_valid_held", 64'(rv[2]), 64'd0);
      rst_v[2] = 1'b0;
      count_init(2, "reinit_ready_low_edges", 1'b0);
      issue(2, 1'b0, 8'h20, '0, '0, 32'h0);
      idle(2);
      repeat (3) @(posedge clk);

      // No clearing: write then read back
      issue(3, 1'b1, 8'h00, 32'h5, 4'hF, '0);
      issue(3, 1'b0, 8'h00, '0, '0, 32'h00000005);
      idle(3);

      for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
